// File: rtl/bcd_pkg.sv
// Shared BCD types and constants for the scanned decimal counter and its
// downstream 7-segment decoder.
package bcd_pkg;

  typedef logic [3:0] bcd_digit_t;

  localparam bcd_digit_t BCD_MAX   = 4'd9;
  // Out-of-range code that the decoder renders as an unlit digit
  localparam bcd_digit_t BCD_BLANK = 4'hF;

  function automatic bcd_digit_t bcd_inc(input bcd_digit_t d);
    return (d == BCD_MAX) ? 4'd0 : d + 4'd1;
  endfunction

endpackage

// File: rtl/bcd_digit_cell.sv
// One decade of the counter: steps 0..9 on carry_in, raising carry_out
// combinationally so carries ripple through all decades in one cycle.
module bcd_digit_cell
  import bcd_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clr,
  input  logic       carry_in,
  output logic [3:0] digit,
  output logic       carry_out
);

  bcd_digit_t value;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      value <= 4'd0;
    end else if (clr) begin
      value <= 4'd0;
    end else if (carry_in) begin
      value <= bcd_inc(value);
    end
  end

  assign digit     = value;
  assign carry_out = carry_in && (value == BCD_MAX);

endmodule

// File: rtl/bcd_counter_scan.sv
// Multi-digit decimal event counter with a free-running digit scanner and
// optional leading-zero blanking, feeding a BCD-to-7-segment decoder.
module bcd_counter_scan
  import bcd_pkg::*;
#(
  parameter int DIGITS   = 4,
  parameter int SCAN_DIV = 1000,
  parameter int LZ_BLANK = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  inc,
  input  logic                  clr,
  output logic [4*DIGITS-1:0]   count_value,
  output logic                  overflow,
  output logic [3:0]            bcd_output,
  output logic [DIGITS-1:0]     digit_sel
);

  localparam int PRE_W = $clog2(SCAN_DIV);
  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(SCAN_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGITS - 1);

  bcd_digit_t       digits [DIGITS];
  logic [PRE_W-1:0] prescaler;
  logic [IDX_W-1:0] idx;
  logic [DIGITS-1:0] blank;
  logic             top_carry;

  genvar gi;
  generate
    for (gi = 0; gi < DIGITS; gi++) begin : gen_cell
      logic       cin;
      logic       cout;
      logic [3:0] dig;

      // Each stage keeps its own carry nets so the ripple is not one looped vector
      if (gi == 0) begin : gen_first
        assign cin = inc;
      end else begin : gen_chain
        assign cin = gen_cell[gi-1].cout;
      end

      bcd_digit_cell u_cell (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (clr),
        .carry_in  (cin),
        .digit     (dig),
        .carry_out (cout)
      );

      assign digits[gi] = dig;
      assign count_value[gi*4 +: 4] = dig;
      assign digit_sel[gi] = (idx == IDX_W'(gi));
    end
  endgenerate

  assign top_carry = gen_cell[DIGITS-1].cout;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow <= 1'b0;
    end else begin
      overflow <= top_carry && !clr;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prescaler <= '0;
      idx       <= '0;
    end else if (prescaler == PRE_LAST) begin
      prescaler <= '0;
      idx       <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
    end else begin
      prescaler <= prescaler + 1'b1;
    end
  end

  // A digit blanks only when it and everything above it are zero; digit 0 never does
  always_comb begin
    logic all_zero_above;
    all_zero_above = 1'b1;
    blank = '0;
    for (int k = DIGITS - 1; k >= 0; k--) begin
      all_zero_above = all_zero_above && (digits[k] == 4'd0);
      blank[k] = (LZ_BLANK != 0) && (k != 0) && all_zero_above;
    end
  end

  assign bcd_output = blank[idx] ? BCD_BLANK : digits[idx];

endmodule

// File: tb/tb_bcd_counter_scan.sv
// Directed bench for bcd_counter_scan: a blanking and a non-blanking
// instance share the same stimulus and are checked against fixed vectors.
module tb_bcd_counter_scan;

  logic        clk;
  logic        rst_n;
  logic        inc;
  logic        clr;
  logic [15:0] count_a, count_b;
  logic        ovf_a, ovf_b;
  logic [3:0]  bcd_a, bcd_b;
  logic [3:0]  sel_a, sel_b;

  int checks;
  int errors;

  bcd_counter_scan #(.DIGITS(4), .SCAN_DIV(4), .LZ_BLANK(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .inc(inc), .clr(clr),
    .count_value(count_a), .overflow(ovf_a), .bcd_output(bcd_a), .digit_sel(sel_a)
  );

  bcd_counter_scan #(.DIGITS(4), .SCAN_DIV(4), .LZ_BLANK(0)) dut_b (
    .clk(clk), .rst_n(rst_n), .inc(inc), .clr(clr),
    .count_value(count_b), .overflow(ovf_b), .bcd_output(bcd_b), .digit_sel(sel_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change and outputs are sampled 1 time unit after the rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulses(input int n);
    inc = 1'b1;
    repeat (n) tick();
    inc = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    inc = 1'b0;
    clr = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    pulses(347);
    checks++;
    if (count_a !== 16'h0347) begin
      errors++; $display("FAIL reset_precount: got %h want 0347", count_a);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (count_a !== 16'h0000 || sel_a !== 4'b0001 || bcd_a !== 4'h0 || ovf_a !== 1'b0) begin
      errors++;
      $display("FAIL reset_async: count %h sel %b bcd %h ovf %b want 0000 0001 0 0",
               count_a, sel_a, bcd_a, ovf_a);
    end
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    tick();
    checks++;
    if (count_a !== 16'h0000 || count_b !== 16'h0000 || ovf_a !== 1'b0) begin
      errors++; $display("FAIL reset_hold: count %h/%h ovf %b want 0000 0", count_a, count_b, ovf_a);
    end
    $display("test_reset done");
  endtask

  task automatic test_carry();
    do_reset();
    pulses(1099);
    checks++;
    if (count_a !== 16'h1099) begin
      errors++; $display("FAIL carry_pre: got %h want 1099", count_a);
    end
    pulses(1);
    checks++;
    if (count_a !== 16'h1100 || ovf_a !== 1'b0) begin
      errors++; $display("FAIL carry_ripple: count %h ovf %b want 1100 0", count_a, ovf_a);
    end
    $display("test_carry done");
  endtask

  task automatic test_wrap();
    do_reset();
    pulses(9999);
    checks++;
    if (count_a !== 16'h9999 || ovf_a !== 1'b0) begin
      errors++; $display("FAIL wrap_pre: count %h ovf %b want 9999 0", count_a, ovf_a);
    end
    pulses(1);
    checks++;
    if (count_a !== 16'h0000 || ovf_a !== 1'b1 || ovf_b !== 1'b1) begin
      errors++; $display("FAIL wrap_edge: count %h ovf %b/%b want 0000 1", count_a, ovf_a, ovf_b);
    end
    tick();
    checks++;
    if (ovf_a !== 1'b0 || count_a !== 16'h0000) begin
      errors++; $display("FAIL wrap_pulse_len: ovf %b count %h want 0 0000", ovf_a, count_a);
    end
    $display("test_wrap done");
  endtask

  task automatic test_clear();
    do_reset();
    pulses(42);
    checks++;
    if (count_a !== 16'h0042) begin
      errors++; $display("FAIL clear_pre: got %h want 0042", count_a);
    end
    inc = 1'b1; clr = 1'b1;
    tick();
    inc = 1'b0; clr = 1'b0;
    checks++;
    if (count_a !== 16'h0000 || ovf_a !== 1'b0) begin
      errors++; $display("FAIL clear_priority: count %h ovf %b want 0000 0", count_a, ovf_a);
    end
    // Clearing on the would-be wrapping cycle must suppress overflow
    pulses(9999);
    inc = 1'b1; clr = 1'b1;
    tick();
    inc = 1'b0; clr = 1'b0;
    checks++;
    if (count_a !== 16'h0000 || ovf_a !== 1'b0) begin
      errors++; $display("FAIL clear_at_max: count %h ovf %b want 0000 0", count_a, ovf_a);
    end
    pulses(3);
    checks++;
    if (count_a !== 16'h0003) begin
      errors++; $display("FAIL clear_resume: got %h want 0003", count_a);
    end
    $display("test_clear done");
  endtask

  // Expects to start right on a frame boundary (prescaler 0, idx 0)
  task automatic scan_frame(input string name, input logic [15:0] exp_a, input logic [15:0] exp_b);
    logic [3:0] want_sel;
    logic [3:0] want_a;
    logic [3:0] want_b;
    for (int j = 0; j < 16; j++) begin
      want_sel = 4'b0001 << (j / 4);
      want_a   = exp_a[(j/4)*4 +: 4];
      want_b   = exp_b[(j/4)*4 +: 4];
      checks++;
      if (sel_a !== want_sel || sel_b !== want_sel || bcd_a !== want_a || bcd_b !== want_b) begin
        errors++;
        $display("FAIL %s cycle %0d: sel %b/%b bcd %h/%h want sel %b bcd %h/%h",
                 name, j, sel_a, sel_b, bcd_a, bcd_b, want_sel, want_a, want_b);
      end
      tick();
    end
  endtask

  task automatic test_scan();
    do_reset();
    scan_frame("scan_zero", 16'hFFF0, 16'h0000);
    do_reset();
    pulses(42);
    repeat (6) tick();
    scan_frame("scan_42", 16'hFF42, 16'h0042);
    $display("test_scan done");
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n = 1'b0;
    inc = 1'b0;
    clr = 1'b0;
    test_reset();
    test_carry();
    test_wrap();
    test_clear();
    test_scan();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
